// File: rtl/dct8_row_pipe_pkg.sv
// dct_pkg: shared constants and helpers for the 8-point row DCT engine.
//   C16/C6/C5/C3/C7 : lifting multipliers (C16 is the x16 lifting scale)
//   OUT_PERM        : output coefficient k is taken from lifting result d[OUT_PERM[k]]
//   sat_round()     : drop frac_w bits, round half up, saturate to out_w signed bits
package dct_pkg;

  localparam int C16 = 16;
  localparam int C6  = 6;
  localparam int C5  = 5;
  localparam int C3  = 3;
  localparam int C7  = 7;

  localparam int OUT_PERM [8] = '{0, 7, 3, 6, 1, 5, 2, 4};

  function automatic logic signed [63:0] sat_round(input logic signed [63:0] value,
                                                   input int frac_w,
                                                   input int out_w);
    logic signed [63:0] q;
    logic signed [63:0] half;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    // Keep one extra bit so the top discarded bit (the 0.5 weight) lands in q[0].
    q    = value >>> (frac_w - 1);
    half = q >>> 1;
    q    = half + $signed({63'd0, q[0]});
    hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (out_w - 1));
    if (q > hi) begin
      q = hi;
    end else if (q < lo) begin
      q = lo;
    end
    return q;
  endfunction

endpackage

// File: rtl/dct8_row_pipe_if.sv
// Row-stream bus of the row DCT engine.
//   i_valid/o_ready/i_data          : input row handshake (8 packed samples, x0 in LSBs)
//   o_valid/i_ready/o_data          : output row handshake (8 packed coefficients, y0 in LSBs)
//   o_row_idx/o_block_last          : row tag of the row currently presented on o_data
// slave = engine side, master = producer/consumer side.
interface dct8_row_pipe_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 12,
  parameter int ROWS  = 8
);
  localparam int RIDX_W = $clog2(ROWS);

  logic                  i_valid;
  logic                  o_ready;
  logic [8*IN_W-1:0]     i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [8*OUT_W-1:0]    o_data;
  logic [RIDX_W-1:0]     o_row_idx;
  logic                  o_block_last;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_row_idx, o_block_last
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_row_idx, o_block_last
  );
endinterface

// File: rtl/dct8_row_pipe_lift_stage.sv
// dct8_lift_stage: one registered step of the row DCT (butterfly or a lifting step).
//   clk, rst          : clock, async active-high reset (clears the valid bit only)
//   en                : global advance enable; the stage holds when low
//   vld_in, dat_in    : incoming row (8 x ACC_W signed, element 0 in LSBs)
//   vld_out, dat_out  : registered result of the equations selected by STAGE (1..4)
module dct8_lift_stage
  import dct_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int STAGE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               vld_in,
  input  logic [8*ACC_W-1:0] dat_in,
  output logic               vld_out,
  output logic [8*ACC_W-1:0] dat_out
);

  localparam logic signed [ACC_W-1:0] D2 = ACC_W'(2);
  localparam logic signed [ACC_W-1:0] D8 = ACC_W'(8);

  // Constant multiply formed 4 bits wider, then wrapped back to the stage width.
  function automatic logic signed [ACC_W-1:0] mulk(input int k,
                                                   input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W+3:0] p;
    p = (ACC_W+4)'(v) * $signed((ACC_W+4)'(k));
    return p[ACC_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] x [8];
  logic signed [ACC_W-1:0] r [8];
  logic signed [ACC_W-1:0] t;

  // "/" below is signed division (truncates toward zero), deliberately not a shift.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      x[i] = dat_in[i*ACC_W +: ACC_W];
    end
    r = x;
    t = '0;
    case (STAGE)
      1: begin
        r[0] = x[0] + x[7];
        r[1] = x[1] + x[6];
        r[2] = x[2] + x[5];
        r[3] = x[3] + x[4];
        r[4] = x[3] - x[4];
        r[5] = x[2] - x[5];
        r[6] = x[1] - x[6];
        r[7] = x[0] - x[7];
      end
      2: begin
        t    = mulk(C6, x[5]) + mulk(C16, x[6]);
        r[0] = mulk(C16, x[0] + x[3]);
        r[1] = mulk(C16, x[1] + x[2]);
        r[2] = mulk(C16, x[1] - x[2]);
        r[3] = mulk(C16, x[0] - x[3]);
        r[4] = mulk(C16, x[4]);
        r[5] = mulk(C5, t) / D8 - mulk(C16, x[5]);
        r[6] = t;
        r[7] = mulk(C16, x[7]);
      end
      3: begin
        r[0] = x[0] + x[1];
        r[1] = x[1];
        r[2] = x[2] - mulk(C3, x[3]) / D8;
        r[3] = x[3];
        r[4] = x[4] + x[5];
        r[5] = x[4] - x[5];
        r[6] = x[7] - x[6];
        r[7] = x[6] + x[7];
      end
      4: begin
        // d5 feeds d6 within the same step
        t    = x[5] + mulk(C7, x[6]) / D8;
        r[0] = x[0];
        r[1] = x[0] / D2 - x[1];
        r[2] = x[2];
        r[3] = x[3] + mulk(C3, x[2]) / D8;
        r[4] = x[4] - x[7] / D8;
        r[5] = t;
        r[6] = x[6] - t / D2;
        r[7] = x[7];
      end
      default: r = x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_out <= 1'b0;
    end else if (en) begin
      vld_out <= vld_in;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        dat_out[i*ACC_W +: ACC_W] <= r[i];
      end
    end
  end

endmodule

// File: rtl/dct8_row_pipe.sv
// dct8_row_pipe: 8-point forward 1-D DCT row engine (butterfly + three lifting steps).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : input row handshake, output coefficient handshake, row tag
// A row accepted at edge N is presented on o_valid/o_data after edge N+4. The whole
// pipeline advances on en = i_ready || !o_valid, which also drives o_ready.
module dct8_row_pipe
  import dct_pkg::*;
#(
  parameter int IN_W   = 12,
  parameter int OUT_W  = 12,
  parameter int FRAC_W = 7,
  parameter int ROWS   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  dct8_row_pipe_if.slave  bus
);

  localparam int ACC_W  = IN_W + 8;
  localparam int RIDX_W = $clog2(ROWS);
  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROWS - 1);

  logic                 en;
  logic [8*ACC_W-1:0]   dat_p0;
  logic [8*ACC_W-1:0]   dat_p1, dat_p2, dat_p3, dat_p4;
  logic                 vld_p1, vld_p2, vld_p3, vld_p4;
  logic [8*OUT_W-1:0]   y_sat;
  logic                 vld_p5;
  logic [8*OUT_W-1:0]   dat_p5;
  logic [RIDX_W-1:0]    row_cnt;

  assign en               = bus.i_ready || !vld_p5;
  assign bus.o_ready      = en;
  assign bus.o_valid      = vld_p5;
  assign bus.o_data       = dat_p5;
  assign bus.o_row_idx    = row_cnt;
  assign bus.o_block_last = (row_cnt == LAST_IDX);

  // Stage p0: sign-extend the incoming samples to the internal width
  always_comb begin
    dat_p0 = '0;
    for (int i = 0; i < 8; i++) begin
      dat_p0[i*ACC_W +: ACC_W] = ACC_W'($signed(bus.i_data[i*IN_W +: IN_W]));
    end
  end

  // Stages p1..p4: butterfly, then the three lifting steps
  dct8_lift_stage #(.ACC_W(ACC_W), .STAGE(1)) u_s1 (
    .clk(i_clk), .rst(i_rst), .en(en),
    .vld_in(bus.i_valid), .dat_in(dat_p0), .vld_out(vld_p1), .dat_out(dat_p1)
  );
  dct8_lift_stage #(.ACC_W(ACC_W), .STAGE(2)) u_s2 (
    .clk(i_clk), .rst(i_rst), .en(en),
    .vld_in(vld_p1), .dat_in(dat_p1), .vld_out(vld_p2), .dat_out(dat_p2)
  );
  dct8_lift_stage #(.ACC_W(ACC_W), .STAGE(3)) u_s3 (
    .clk(i_clk), .rst(i_rst), .en(en),
    .vld_in(vld_p2), .dat_in(dat_p2), .vld_out(vld_p3), .dat_out(dat_p3)
  );
  dct8_lift_stage #(.ACC_W(ACC_W), .STAGE(4)) u_s4 (
    .clk(i_clk), .rst(i_rst), .en(en),
    .vld_in(vld_p3), .dat_in(dat_p3), .vld_out(vld_p4), .dat_out(dat_p4)
  );

  // Stage p5: reorder, scale and saturate into the output register
  for (genvar k = 0; k < 8; k++) begin : g_out
    logic signed [ACC_W-1:0] dk;
    assign dk = dat_p4[OUT_PERM[k]*ACC_W +: ACC_W];
    assign y_sat[k*OUT_W +: OUT_W] = OUT_W'(sat_round(64'(dk), FRAC_W, OUT_W));
  end

  // The output register is cleared on reset so o_data reads zero until the first row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p5 <= 1'b0;
      dat_p5 <= '0;
    end else if (en) begin
      vld_p5 <= vld_p4;
      dat_p5 <= y_sat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row_cnt <= '0;
    end else if (vld_p5 && bus.i_ready) begin
      row_cnt <= (row_cnt == LAST_IDX) ? '0 : row_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dct8_row_pipe.sv
// Testbench for dct8_row_pipe: directed DC/impulse/saturation rows, randomized rows
// under random backpressure against a behavioural DCT model, block tagging and
// mid-stream reset.
module tb_dct8_row_pipe;

  localparam int IN_W  = 12;
  localparam int OUT_W = 12;
  localparam int SAT_W = 8;
  localparam int ROWS  = 8;

  typedef int row_t [8];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct8_row_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ROWS(ROWS)) bus ();
  dct8_row_pipe_if #(.IN_W(IN_W), .OUT_W(SAT_W), .ROWS(ROWS)) bus8 ();

  dct8_row_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_W(7), .ROWS(ROWS)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  dct8_row_pipe #(.IN_W(IN_W), .OUT_W(SAT_W), .FRAC_W(7), .ROWS(ROWS)) dut8 (
    .i_clk(clk), .i_rst(rst), .bus(bus8)
  );

  int checks = 0;
  int errors = 0;

  logic [8*OUT_W-1:0] exp_q [$];
  int                 exp_idx;
  int                 out_cnt;
  logic [15:0]        last_mask;
  logic               stall_prev;
  logic [8*OUT_W-1:0] data_prev;

  // ---------------- reference model ----------------
  function automatic int round_sat(int v, int ow);
    int q;
    int hi;
    int lo;
    q  = (v + 64) >>> 7;          // floor(v/128 + 1/2)
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic dct_ref(input row_t x, input int ow, output row_t y);
    int a0, a1, a2, a3, a4, a5, a6, a7;
    int b0, b1, b2, b3, b4, b5, b6, b7;
    int c0, c1, c2, c3, c4, c5, c6, c7;
    int d0, d1, d2, d3, d4, d5, d6, d7;
    a0 = x[0] + x[7]; a1 = x[1] + x[6]; a2 = x[2] + x[5]; a3 = x[3] + x[4];
    a4 = x[3] - x[4]; a5 = x[2] - x[5]; a6 = x[1] - x[6]; a7 = x[0] - x[7];
    b0 = 16 * (a0 + a3); b1 = 16 * (a1 + a2); b2 = 16 * (a1 - a2); b3 = 16 * (a0 - a3);
    b4 = 16 * a4; b7 = 16 * a7;
    b6 = 6 * a5 + 16 * a6;
    b5 = (5 * b6) / 8 - 16 * a5;
    c0 = b0 + b1; c1 = b1; c2 = b2 - (3 * b3) / 8; c3 = b3;
    c4 = b4 + b5; c5 = b4 - b5; c6 = b7 - b6; c7 = b6 + b7;
    d0 = c0; d1 = c0 / 2 - c1; d2 = c2; d3 = c3 + (3 * c2) / 8;
    d4 = c4 - c7 / 8; d5 = c5 + (7 * c6) / 8; d6 = c6 - d5 / 2; d7 = c7;
    y[0] = round_sat(d0, ow); y[1] = round_sat(d7, ow);
    y[2] = round_sat(d3, ow); y[3] = round_sat(d6, ow);
    y[4] = round_sat(d1, ow); y[5] = round_sat(d5, ow);
    y[6] = round_sat(d2, ow); y[7] = round_sat(d4, ow);
  endtask

  function automatic logic [8*IN_W-1:0] pack_in(row_t x);
    logic [8*IN_W-1:0] v;
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = x[i];
      v[i*IN_W +: IN_W] = w[IN_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [8*OUT_W-1:0] pack_out(row_t y);
    logic [8*OUT_W-1:0] v;
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = y[i];
      v[i*OUT_W +: OUT_W] = w[OUT_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [8*SAT_W-1:0] pack_sat(row_t y);
    logic [8*SAT_W-1:0] v;
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = y[i];
      v[i*SAT_W +: SAT_W] = w[SAT_W-1:0];
    end
    return v;
  endfunction

  task automatic rand_row(output row_t x);
    for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(1023)) - 512;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus on the main bus; entered and left just after a negedge.
  task automatic step(input logic iv, input row_t x, input logic rdy, output logic acc);
    row_t y;
    logic [8*OUT_W-1:0] e;
    if (stall_prev) begin
      chk("stall_valid", 128'(bus.o_valid), 128'(1'b1));
      chk("stall_data", 128'(bus.o_data), 128'(data_prev));
    end
    bus.i_valid = iv;
    bus.i_data  = pack_in(x);
    bus.i_ready = rdy;
    #1;
    chk("o_ready", 128'(bus.o_ready), 128'(rdy || !bus.o_valid));
    acc = iv && bus.o_ready;
    if (acc) begin
      dct_ref(x, OUT_W, y);
      exp_q.push_back(pack_out(y));
    end
    if (bus.o_valid && rdy) begin
      chk("row_expected", 128'(exp_q.size() > 0), 128'(1'b1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("row_data", 128'(bus.o_data), 128'(e));
      end
      chk("row_idx", 128'(bus.o_row_idx), 128'(exp_idx));
      chk("block_last", 128'(bus.o_block_last), 128'(exp_idx == ROWS - 1));
      if (bus.o_block_last && out_cnt < 16) last_mask[out_cnt] = 1'b1;
      out_cnt++;
      exp_idx = (exp_idx + 1) % ROWS;
    end
    stall_prev = bus.o_valid && !rdy;
    data_prev  = bus.o_data;
    @(negedge clk);
  endtask

  task automatic drain(input logic random_ready);
    row_t z;
    logic acc;
    int guard;
    z = '{default: 0};
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      step(1'b0, z, random_ready ? logic'($urandom_range(1)) : 1'b1, acc);
      guard++;
    end
    chk("drain_bound", 128'(exp_q.size()), 128'(0));
  endtask

  // Single row with an idle pipeline: checks the exact 4-edge latency.
  task automatic single_row(input string tag, input row_t x, input row_t y, input int idx);
    bus.i_valid = 1'b1;
    bus.i_data  = pack_in(x);
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_early_valid"}, 128'(bus.o_valid), 128'(1'b0));
      @(negedge clk);
    end
    chk({tag, "_valid"}, 128'(bus.o_valid), 128'(1'b1));
    chk({tag, "_data"}, 128'(bus.o_data), 128'(pack_out(y)));
    chk({tag, "_idx"}, 128'(bus.o_row_idx), 128'(idx));
    @(negedge clk);
    chk({tag, "_consumed"}, 128'(bus.o_valid), 128'(1'b0));
    exp_idx = (idx + 1) % ROWS;
  endtask

  task automatic sat_row(input string tag, input int v, input row_t y);
    row_t x;
    x = '{default: v};
    bus8.i_valid = 1'b1;
    bus8.i_data  = pack_in(x);
    @(posedge clk);
    @(negedge clk);
    bus8.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_valid"}, 128'(bus8.o_valid), 128'(1'b1));
    chk({tag, "_data"}, 128'(bus8.o_data), 128'(pack_sat(y)));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    row_t x;
    row_t y;
    logic acc;
    int sent;
    int guard;

    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ready = 1'b1;
    bus8.i_valid = 1'b0; bus8.i_data = '0; bus8.i_ready = 1'b1;
    exp_idx = 0; out_cnt = 0; last_mask = '0; stall_prev = 1'b0; data_prev = '0;
    repeat (2) @(negedge clk);

    chk("rst_valid", 128'(bus.o_valid), 128'(1'b0));
    chk("rst_data", 128'(bus.o_data), 128'(0));
    chk("rst_idx", 128'(bus.o_row_idx), 128'(0));
    chk("rst_last", 128'(bus.o_block_last), 128'(1'b0));
    rst = 1'b0;
    #1;
    chk("rel_ready", 128'(bus.o_ready), 128'(1'b1));
    @(negedge clk);

    // DC row
    x = '{default: 10};
    y = '{10, 0, 0, 0, 0, 0, 0, 0};
    single_row("dc", x, y, 0);

    // Impulse row
    x = '{100, 0, 0, 0, 0, 0, 0, 0};
    y = '{13, 13, 11, 7, 6, 11, -5, -2};
    single_row("impulse", x, y, 1);

    // Saturation on the 8-bit output instance
    sat_row("sat_pos", 200, '{127, 0, 0, 0, 0, 0, 0, 0});
    sat_row("sat_neg", -200, '{-128, 0, 0, 0, 0, 0, 0, 0});

    // Random rows under random backpressure
    sent = 0;
    guard = 0;
    while (sent < 16 && guard < 500) begin
      rand_row(x);
      step(logic'($urandom_range(3) != 0), x, logic'($urandom_range(1)), acc);
      if (acc) sent++;
      guard++;
    end
    chk("bp_sent", 128'(sent), 128'(16));
    drain(1'b1);

    // Mid-stream reset with rows in flight and one row at the output
    for (int i = 0; i < 5; i++) begin
      rand_row(x);
      step(1'b1, x, 1'b1, acc);
    end
    chk("pre_reset_valid", 128'(bus.o_valid), 128'(1'b1));
    bus.i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 128'(bus.o_valid), 128'(1'b0));
    chk("midrst_data", 128'(bus.o_data), 128'(0));
    chk("midrst_idx", 128'(bus.o_row_idx), 128'(0));
    chk("midrst_last", 128'(bus.o_block_last), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rel_ready", 128'(bus.o_ready), 128'(1'b1));
    @(negedge clk);
    exp_q.delete();
    exp_idx = 0; out_cnt = 0; stall_prev = 1'b0;
    rand_row(x);
    step(1'b1, x, 1'b1, acc);
    drain(1'b0);
    x = '{default: 0};
    for (int i = 0; i < 8; i++) step(1'b0, x, 1'b1, acc);
    chk("midrst_out_count", 128'(out_cnt), 128'(1));

    // Block tagging over two blocks, from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    exp_idx = 0; out_cnt = 0; last_mask = '0; stall_prev = 1'b0;
    for (int i = 0; i < 2 * ROWS; i++) begin
      rand_row(x);
      step(1'b1, x, 1'b1, acc);
    end
    drain(1'b0);
    chk("block_count", 128'(out_cnt), 128'(2 * ROWS));
    chk("block_last_mask", 128'(last_mask), 128'(16'h8080));
    chk("block_idx_wrap", 128'(bus.o_row_idx), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
